// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: data width, read-select encodings used by the
// address decoder and this register stage, and the default debounce depth.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;
  localparam int DEB_CYCLES_DEFAULT = 4;

  localparam logic [1:0] RDSEL_IN1  = 2'b00;
  localparam logic [1:0] RDSEL_IN2  = 2'b01;
  localparam logic [1:0] RDSEL_OUT1 = 2'b10;
  localparam logic [1:0] RDSEL_OUT2 = 2'b11;

  // Debounce counter must reach DEB_CYCLES; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One asynchronous input channel: two-flop synchroniser followed by a
// whole-word debouncer that publishes a value once it has held steady.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH      = GPIO_WIDTH,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pub
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pub <= '0;
        else     pub <= s2;
      end
    end else begin : g_debounce
      localparam int CW = cnt_width(DEB_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
      localparam logic [CW-1:0] CNT_SAT  = CW'(DEB_CYCLES);

      logic [WIDTH-1:0] smp;
      logic [CW-1:0]    cnt;

      // Any bit change restarts the count; once published, cnt parks at
      // CNT_SAT so the same word is not re-published every cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          smp <= '0;
          cnt <= '0;
          pub <= '0;
        end else if (s2 != smp) begin
          smp <= s2;
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          pub <= smp;
          cnt <= CNT_SAT;
        end else if (cnt < CNT_LAST) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/gpio_regs.sv
// GPIO register/data stage: two CPU-written output ports, two debounced
// input ports and the combinational read-data mux back to the CPU.
module gpio_regs
  import gpio_pkg::*;
#(
  parameter int WIDTH      = GPIO_WIDTH,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE1,
  input  logic             WE2,
  input  logic [1:0]       RdSel,
  input  logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] gpI1,
  input  logic [WIDTH-1:0] gpI2,
  output logic [WIDTH-1:0] RD,
  output logic [WIDTH-1:0] gpO1,
  output logic [WIDTH-1:0] gpO2
);

  logic [WIDTH-1:0] pub1;
  logic [WIDTH-1:0] pub2;

  // Enables are independent so a (never expected) double write loads both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpO1 <= '0;
      gpO2 <= '0;
    end else begin
      if (WE1) gpO1 <= WD;
      if (WE2) gpO2 <= WD;
    end
  end

  gpio_debounce #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_in1 (
    .clk (clk),
    .rst (rst),
    .din (gpI1),
    .pub (pub1)
  );

  gpio_debounce #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_in2 (
    .clk (clk),
    .rst (rst),
    .din (gpI2),
    .pub (pub2)
  );

  always_comb begin
    RD = '0;
    case (RdSel)
      RDSEL_IN1:  RD = pub1;
      RDSEL_IN2:  RD = pub2;
      RDSEL_OUT1: RD = gpO1;
      RDSEL_OUT2: RD = gpO2;
    endcase
  end

endmodule

// File: doc/gpio_regs.md
Name: gpio_regs

Overview:
- Register and data stage of the memory-mapped GPIO peripheral. It sits directly downstream of the GPIO address decoder and consumes WE1, WE2 and RdSel.
- Holds the two output ports and brings the two asynchronous input ports into the clock domain through a synchroniser and debouncer.
- Returns the selected word on RD to the CPU read-data mux.

Parameters:
- WIDTH, 32: data width of every port and register.
- DEB_CYCLES, 4: number of consecutive cycles a synchronised input word must hold before it is published. 0 = no debounce: published value follows the sync output directly.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- WE1  in  1  write enable for output register 1, from the address decoder.
- WE2  in  1  write enable for output register 2, from the address decoder.
- RdSel  in  2  read select, from the address decoder.
- WD  in  WIDTH  CPU write data.
- gpI1  in  WIDTH  external input port 1, asynchronous.
- gpI2  in  WIDTH  external input port 2, asynchronous.
- RD  out  WIDTH  read data to the CPU.
- gpO1  out  WIDTH  external output port 1, registered.
- gpO2  out  WIDTH  external output port 2, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: clears the following to 0 immediately on rst, independent of clk:
  - gpO1 and gpO2
  - both sync stages of each channel
  - the sample register smp of each channel
  - the debounce counter cnt of each channel
  - the published input pub of each channel
- Reset mid-debounce: abandons the count. After rst deasserts, the channel restarts from the zero state.
- Output writes:
  - At a rising clk edge, WE1=1 loads gpO1 from WD, and WE2=1 loads gpO2 from WD.
  - The decoder never asserts both enables together. If it does, both registers load WD.
  - Write-enable low: the register holds its value.
  - gpO1 and gpO2 are driven directly from the registers, with no combinational path from WD.
- Input channel, per port, identical logic:
  - Sync: s1 samples gpI at each edge; s2 samples s1 at each edge.
  - Debounce, for DEB_CYCLES >= 1, evaluated at each edge:
    - If s2 != smp: smp <= s2 and cnt <= 0.
    - Else if cnt == DEB_CYCLES-1: pub <= smp and cnt <= DEB_CYCLES (saturates).
    - Else if cnt < DEB_CYCLES-1: cnt <= cnt+1.
    - Else (cnt == DEB_CYCLES): hold.
  - Latency: an input change stable from before edge k reaches pub at edge k+2+DEB_CYCLES. With DEB_CYCLES=4, pub updates at edge k+6.
  - Glitch rejection: any change that leaves s2 before smp has stayed equal to s2 for DEB_CYCLES consecutive edges never reaches pub.
  - Multi-bit changes: the whole word is debounced as one unit. A change in any bit restarts the count.
  - Counter width: clog2(DEB_CYCLES+1), minimum 1 bit.
  - DEB_CYCLES = 0: pub <= s2 every edge, giving latency k+2.
- Read mux, combinational, no added latency:
  - RdSel 00 -> pub1
  - RdSel 01 -> pub2
  - RdSel 10 -> gpO1
  - RdSel 11 -> gpO2
  - RdSel X/Z: RD is don't-care.
- Read-after-write: RdSel=10 with WE1=1 returns the old gpO1 in that cycle and the new value from the next cycle.

Decomposition:
- Shared package gpio_pkg holds:
  - GPIO_WIDTH = 32
  - RdSel encodings RDSEL_IN1 = 2'b00, RDSEL_IN2 = 2'b01, RDSEL_OUT1 = 2'b10, RDSEL_OUT2 = 2'b11, also used by the address decoder
  - default DEB_CYCLES
- One sub-module, gpio_debounce, parameterised by WIDTH and DEB_CYCLES.
  - Contains the sync pair, smp, cnt and pub.
  - Instantiated twice, once per input channel.
- Output registers and the read mux stay in gpio_regs.

Test Plan:
- Reset: set rst=1 mid-operation with gpO1=32'hDEADBEEF -> gpO1, gpO2 and RD (all RdSel values) read 0 before the next clk edge.
- Write/readback: WE1=1, WD=32'h0000_00A5 for one cycle -> gpO1=32'hA5 after that edge, gpO2 unchanged. RdSel=10 returns 32'hA5 from the following cycle. Repeat with WE2 and 32'h1234_5678 on RdSel=11.
- Input latency (DEB_CYCLES=4): gpI1 steps 0 -> 32'h0000_00FF before edge k, RdSel=00 -> RD=0 through edge k+5, RD=32'hFF from edge k+6.
- Glitch rejection (DEB_CYCLES=4): gpI2 set to 32'h1 for 3 cycles, then back to 0 -> RdSel=01 reads 0 throughout. A 6-cycle pulse is published 6 edges after it starts and cleared 6 edges after it ends.
- Bit bounce: gpI1 toggles bit 3 every 2 cycles for 20 cycles, then settles at 32'h8 -> pub1 stays at its old value until 6 edges after the settle.
- Bypass (DEB_CYCLES=0): gpI1=32'hCAFE_F00D before edge k -> RD (RdSel=00) equals 32'hCAFEF00D from edge k+2.
